// File: rtl/row_bias.sv
// Per-row value-ordering source: holds an LFSR-shuffled permutation of the LEN one-hot
// values and answers a tile's one-hot slot request with the value at that slot.
module row_bias #(
  parameter int unsigned LEN = 9
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [15:0]    seed,
  input  logic           reshuffle,
  output logic           ready,
  input  logic           rq_valtotry,
  input  logic [LEN-1:0] biasidx,
  output logic [LEN-1:0] valtotry
);

  localparam int unsigned IW = $clog2(LEN);
  localparam logic [IW-1:0] IMax = IW'(LEN - 1);
  localparam logic [LEN-1:0] OneLsb = {{(LEN-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    StInit    = 3'b001,
    StShuffle = 3'b010,
    StReady   = 3'b100
  } state_e;

  state_e          state_q, state_d;
  logic [LEN-1:0]  perm_q [LEN];
  logic [LEN-1:0]  perm_d [LEN];
  logic [15:0]     lfsr_q, lfsr_d, lfsr_next, j_wide;
  logic [IW-1:0]   i_q, i_d, j;
  logic [LEN-1:0]  val_q, val_d, lookup;
  logic            idx_onehot;

  assign lfsr_next  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign j_wide     = lfsr_q % (16'(i_q) + 16'd1);
  assign j          = j_wide[IW-1:0];
  assign idx_onehot = (biasidx != '0) && ((biasidx & (biasidx - OneLsb)) == '0);

  // OR-select: equals perm[k] whenever biasidx is one-hot at k.
  always_comb begin
    lookup = '0;
    for (int k = 0; k < LEN; k++) begin
      if (biasidx[k]) lookup = lookup | perm_q[k];
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    i_d     = i_q;
    val_d   = val_q;
    perm_d  = perm_q;
    unique case (state_q)
      StInit: begin
        for (int k = 0; k < LEN; k++) perm_d[k] = OneLsb << k;
        lfsr_d  = (seed == 16'h0000) ? 16'hACE1 : seed;
        i_d     = IMax;
        val_d   = '0;
        state_d = StShuffle;
      end
      StShuffle: begin
        // Fisher-Yates step; j == i writes the same entry back.
        perm_d[j]   = perm_q[i_q];
        perm_d[i_q] = perm_q[j];
        lfsr_d      = lfsr_next;
        val_d       = '0;
        if (i_q == IW'(1)) state_d = StReady;
        else               i_d     = i_q - IW'(1);
      end
      StReady: begin
        if (reshuffle) begin
          i_d     = IMax;
          val_d   = '0;
          state_d = StShuffle;
        end else if (rq_valtotry) begin
          val_d = idx_onehot ? lookup : '0;
        end
      end
      default: state_d = StInit;
    endcase
    if (reset) begin
      state_d = StInit;
      val_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    state_q <= state_d;
    lfsr_q  <= lfsr_d;
    i_q     <= i_d;
    val_q   <= val_d;
    perm_q  <= perm_d;
  end

  assign ready    = (state_q == StReady);
  assign valtotry = val_q;

endmodule

// File: tb/tb_row_bias.sv
// Randomized self-checking bench for row_bias against a Fisher-Yates reference model.
module tb_row_bias;

  localparam int LEN = 9;

  logic           clock = 1'b0;
  logic           reset;
  logic [15:0]    seed;
  logic           reshuffle;
  logic           ready;
  logic           rq_valtotry;
  logic [LEN-1:0] biasidx;
  logic [LEN-1:0] valtotry;

  row_bias #(.LEN(LEN)) dut (
    .clock       (clock),
    .reset       (reset),
    .seed        (seed),
    .reshuffle   (reshuffle),
    .ready       (ready),
    .rq_valtotry (rq_valtotry),
    .biasidx     (biasidx),
    .valtotry    (valtotry)
  );

  always #5 clock = ~clock;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // Model: mperm[k] is the bit position of the value stored at slot k.
  int          mperm [LEN];
  int          prev  [LEN];
  logic [15:0] mlfsr;
  logic [LEN-1:0] exp_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [LEN-1:0] onehot(input int b);
    logic [LEN-1:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic int popcount(input logic [LEN-1:0] v);
    int c = 0;
    for (int b = 0; b < LEN; b++) c += int'(v[b]);
    return c;
  endfunction

  function automatic int slot_of(input logic [LEN-1:0] v);
    for (int b = 0; b < LEN; b++) if (v[b]) return b;
    return 0;
  endfunction

  task automatic model_shuffle();
    int j, t;
    for (int i = LEN - 1; i >= 1; i--) begin
      j = int'(mlfsr % 16'(i + 1));
      t = mperm[i]; mperm[i] = mperm[j]; mperm[j] = t;
      mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
    end
  endtask

  task automatic model_reset(input logic [15:0] s);
    for (int k = 0; k < LEN; k++) mperm[k] = k;
    mlfsr = (s == 16'h0000) ? 16'hACE1 : s;
    model_shuffle();
  endtask

  task automatic wait_ready(input string tag, input int exp_edges);
    int n = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (ready) begin n = e; break; end
    end
    check(tag, 32'(n), 32'(exp_edges));
  endtask

  task automatic do_reset(input logic [15:0] s);
    seed = s; reset = 1'b1; rq_valtotry = 1'b0; reshuffle = 1'b0; biasidx = '0;
    tick(); tick();
    reset = 1'b0;
    exp_val = '0;
  endtask

  task automatic sweep(input string tag);
    logic [LEN-1:0] acc = '0;
    for (int k = 0; k < LEN; k++) begin
      rq_valtotry = 1'b1; biasidx = onehot(k);
      tick();
      exp_val = onehot(mperm[k]);
      check({tag, "_slot"}, 32'(valtotry), 32'(exp_val));
      acc |= valtotry;
    end
    rq_valtotry = 1'b0;
    check({tag, "_cover"}, 32'(acc), 32'({LEN{1'b1}}));
  endtask

  initial begin
    int diff;
    logic [LEN-1:0] held, idx;
    reset = 1'b1; seed = '0; reshuffle = 1'b0; rq_valtotry = 1'b0; biasidx = '0;

    // Readiness with seed 0 (mapped to ACE1)
    do_reset(16'h0000);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_val", 32'(valtotry), 32'd0);
    model_reset(16'h0000);
    wait_ready("ready_lat", LEN);
    sweep("seed0");

    // Sentinels after a hit so zero is distinguishable
    rq_valtotry = 1'b1; biasidx = onehot(3); tick();
    exp_val = onehot(mperm[3]);
    check("pre_sentinel", 32'(valtotry), 32'(exp_val));
    biasidx = '0; tick();
    check("sentinel_zero", 32'(valtotry), 32'd0);
    biasidx = 9'b000000011; tick();
    check("sentinel_multi", 32'(valtotry), 32'd0);

    // Hold with rq low
    biasidx = onehot(5); tick();
    held = onehot(mperm[5]);
    check("hold_hit", 32'(valtotry), 32'(held));
    rq_valtotry = 1'b0;
    for (int c = 0; c < 5; c++) begin
      biasidx = LEN'($urandom);
      tick();
      check("hold", 32'(valtotry), 32'(held));
    end

    // Reshuffle together with a request: reshuffle wins
    for (int k = 0; k < LEN; k++) prev[k] = mperm[k];
    reshuffle = 1'b1; rq_valtotry = 1'b1; biasidx = onehot(0);
    tick();
    reshuffle = 1'b0;
    check("resh_ready", 32'(ready), 32'd0);
    check("resh_val", 32'(valtotry), 32'd0);
    model_shuffle();
    begin
      int n = 0;
      for (int e = 1; e <= 40; e++) begin
        biasidx = onehot(int'($urandom_range(LEN - 1)));
        tick();
        if (ready) begin n = e; break; end
        check("busy_val", 32'(valtotry), 32'd0);
      end
      check("resh_lat", 32'(n), 32'(LEN - 1));
    end
    rq_valtotry = 1'b0;
    sweep("resh");
    diff = 0;
    for (int k = 0; k < LEN; k++) if (mperm[k] != prev[k]) diff = 1;
    for (int k = 0; k < LEN; k++) begin
      rq_valtotry = 1'b1; biasidx = onehot(k); tick();
      if (slot_of(valtotry) != prev[k]) diff |= 2;
    end
    rq_valtotry = 1'b0;
    check("resh_differs", 32'(diff != 0 && (diff & 2) != 0), 32'd1);
    exp_val = onehot(mperm[LEN - 1]);

    // Reset mid-shuffle, seed 1
    do_reset(16'h0001);
    model_reset(16'h0001);
    for (int e = 0; e < 3; e++) tick();
    reset = 1'b1; tick();
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_val", 32'(valtotry), 32'd0);
    reset = 1'b0;
    wait_ready("midrst_lat", LEN);
    sweep("seed1");

    // Random traffic over random seeds
    for (int s = 0; s < 4; s++) begin
      logic [15:0] rs;
      rs = 16'($urandom);
      if (s == 0) rs = 16'h0000;
      do_reset(rs);
      model_reset(rs);
      wait_ready("rnd_lat", LEN);
      for (int c = 0; c < 40; c++) begin
        rq_valtotry = 1'($urandom_range(1));
        if ($urandom_range(9) < 7) idx = onehot(int'($urandom_range(LEN - 1)));
        else                       idx = LEN'($urandom);
        biasidx = idx;
        tick();
        if (rq_valtotry) exp_val = (popcount(idx) == 1) ? onehot(mperm[slot_of(idx)]) : '0;
        check("rnd_val", 32'(valtotry), 32'(exp_val));
      end
      check("rnd_ready", 32'(ready), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/row_bias.md
# row_bias

Per-row value-ordering source for the brute-force solver. Holds a pseudo-random permutation of the `LEN` one-hot cell values, shuffled after reset by an internal LFSR. It answers the active tile's one-hot index request with the one-hot value at that permutation slot, one cycle later. It sits directly upstream of every tile in its row, driving their shared `valtotry`.

## Interface

Parameters:
- `LEN`, default `GRID_LEN` (9): number of values; also the permutation length. Valid range 2..25.

Ports:
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `seed`  in  16  LFSR seed, sampled in INIT. `0` is replaced by `16'hACE1`.
- `reshuffle`  in  1  single-cycle pulse: regenerate the permutation. Honoured only in READY.
- `ready`  out  1  high only in READY. Row tiles must not be given `myturn` while it is low.
- `rq_valtotry`  in  1  OR of the row tiles' request strobes.
- `biasidx`  in  LEN  one-hot slot index from the requesting tile (OR of the tiles' outputs).
- `valtotry`  out  LEN  registered one-hot reply; all-zero means no value.

## Operation

- Storage: `perm[0..LEN-1]`, each a LEN-bit one-hot register; 16-bit register `lfsr`; slot counter `i` of width clog2(LEN).
- LFSR: Fibonacci, left shift. `fb = l[15]^l[13]^l[12]^l[10]`; next value is `{l[14:0], fb}`. It advances only in SHUFFLE cycles.
- States, one-hot encoded as INIT, SHUFFLE, READY.
- `reset` forces INIT from any state.
- INIT:
  - `perm[k] <= 1<<k`.
  - `lfsr <= seed` (or `16'hACE1` when `seed` is 0).
  - `i <= LEN-1`.
  - `valtotry <= 0`.
  - Next state is SHUFFLE.
- SHUFFLE (Fisher-Yates, one swap per cycle):
  - `j = lfsr % (i+1)`, an unsigned 16-bit modulo.
  - Swap `perm[i]` and `perm[j]`; `j == i` is a no-op.
  - Advance `lfsr`. When `i == 1` go to READY, otherwise `i <= i-1`.
  - Requests in this state are ignored and `valtotry` holds 0.
- READY, lookup path:
  - When `rq_valtotry` is high and `biasidx` is exactly one-hot at bit k, `valtotry <= perm[k]`.
  - When `rq_valtotry` is high and `biasidx` is zero or multi-hot, `valtotry <= 0`. A zero index is the tile's "exhausted" sentinel.
  - When `rq_valtotry` is low, `valtotry` holds its value.
- READY, reshuffle path:
  - `reshuffle` high: `i <= LEN-1`, `valtotry <= 0`, next state SHUFFLE. `lfsr` is not reseeded, so a new permutation results.
  - `reshuffle` and `rq_valtotry` high in the same cycle: reshuffle wins and the request is dropped.
- Invariant: in READY, the OR of all `perm` entries equals all-ones and each entry is exactly one-hot.

## Timing

- Reset values: `ready = 0`, `valtotry = 0`. Outputs are registered and glitch-free.
- `ready` rise: `ready` rises after exactly `LEN` rising edges with `reset` low. That is 1 edge INIT→SHUFFLE, then `LEN-1` swap edges, the last of which lands in READY.
- After `reshuffle` is accepted: `ready` falls on the next edge and rises again `LEN-1` edges later.
- Lookup latency is 1 cycle: request in cycle t, valid `valtotry` from cycle t+1. This matches the tile's request-then-load sequence.
- Back-to-back requests are allowed, one per cycle.
- `reset` asserted mid-SHUFFLE or mid-lookup: the next edge is INIT, `valtotry` is 0 and `ready` is 0.

## Test plan

- Readiness: `LEN=9`, `seed=0`, release reset. `ready` goes high on exactly the 9th edge. Sweep `biasidx` 1<<0..1<<8: the replies form a permutation of {1<<0..1<<8}, with no duplicates and none zero.
- LFSR: `seed=16'h0001`. The first SHUFFLE swap uses `j = 1 % 9 = 1`, then `lfsr` becomes `16'h0002`. A bench model of the swap sequence must match all 9 `perm` entries in READY.
- Sentinel: in READY, `rq_valtotry=1` with `biasidx=0` → `valtotry=0` next cycle. With `biasidx=9'b000000011` → `valtotry=0`.
- Hold and busy: a request during SHUFFLE → `valtotry` stays 0. In READY, with `rq_valtotry` low for 5 cycles after a hit → `valtotry` is unchanged.
- Reshuffle: pulse `reshuffle` and `rq_valtotry` together in READY. Next cycle `ready=0`, `valtotry=0`. `ready` returns 8 edges later with a valid permutation that differs from the previous one for `seed=16'hACE1`.
- Reset mid-shuffle: assert `reset` on the 4th SHUFFLE edge and release it. The sequence restarts from identity: same final permutation as a clean reset with the same seed, and `ready` rises after 9 edges.
